median_filter_line_ctrl: RTL and testbench

MEDIAN_FILTER_LINE_CTRL -- requirements
Module: median_filter_line_ctrl

---
 rtl/median_filter_line_ctrl.sv | 133 +++++++++++++
 tb/tb_median_filter_line_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/median_filter_line_ctrl.sv
// Median filter line-stack controller: streams pixels into a cascaded
// line FIFO stack, then drains the stack once the frame is complete.
module median_filter_line_ctrl #(
  parameter int SIZE    = 3,
  parameter int DW_FIFO = 9,
  parameter int BUF_LEN = 4096
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [15:0]        cfg_line_width,
  input  logic [15:0]        cfg_num_lines,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               s_valid,
  input  logic [DW_FIFO-1:0] s_data,
  output logic               s_ready,
  output logic               line_stack_wr_en,
  output logic [DW_FIFO-1:0] line_stack_din,
  output logic               line_stack_glb_rd_en,
  output logic [15:0]        rcvd_line_cntr,
  input  logic               stack_oflow,
  input  logic               stack_uflow,
  output logic               col_valid
);

  localparam int FW_MIN = 16 + $clog2(SIZE + 1);
  localparam int FW     = (FW_MIN < 19) ? 19 : FW_MIN;
  localparam logic [15:0] SZ = 16'(SIZE);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t          state_q;
  logic [15:0]     width_q;
  logic [15:0]     lines_q;
  logic [15:0]     col_cnt_q;
  logic [15:0]     line_cnt_q;
  logic [15:0]     rcvd_q;
  logic [FW-1:0]   flush_q;
  logic            col_valid_q;
  logic            err_q;

  logic            accept;
  logic            last_col;
  logic            last_line;
  logic            cfg_zero;
  logic            cfg_over;
  logic [15:0]     rcvd_inc;
  logic [FW-1:0]   flush_len;

  assign s_ready   = (state_q == STREAM);
  assign accept    = s_valid && s_ready;
  assign last_col  = (col_cnt_q == width_q - 16'd1);
  assign last_line = (line_cnt_q == lines_q - 16'd1);
  assign cfg_zero  = (cfg_line_width == 16'd0) ||
                     (cfg_num_lines == 16'd0);
  assign cfg_over  = 32'(cfg_line_width) > 32'(BUF_LEN);
  assign rcvd_inc  = (rcvd_q == SZ) ? SZ : rcvd_q + 16'd1;
  // Drain length uses the post-increment line count of the final line.
  assign flush_len = FW'(width_q) * FW'(rcvd_inc);

  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign err                  = err_q;
  assign col_valid            = col_valid_q;
  assign rcvd_line_cntr       = rcvd_q;
  assign line_stack_wr_en     = accept;
  assign line_stack_din       = accept ? s_data : '0;
  assign line_stack_glb_rd_en = (accept && (rcvd_q != 16'd0)) ||
                                (state_q == FLUSH);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      width_q     <= '0;
      lines_q     <= '0;
      col_cnt_q   <= '0;
      line_cnt_q  <= '0;
      rcvd_q      <= '0;
      flush_q     <= '0;
      col_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      col_valid_q <= accept && (rcvd_q == SZ);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            width_q    <= cfg_line_width;
            lines_q    <= cfg_num_lines;
            col_cnt_q  <= '0;
            line_cnt_q <= '0;
            err_q      <= !cfg_zero && cfg_over;
            state_q    <= (cfg_zero || cfg_over) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_col) begin
              col_cnt_q <= '0;
              rcvd_q    <= rcvd_inc;
              if (last_line) begin
                line_cnt_q <= '0;
                flush_q    <= flush_len;
                state_q    <= FLUSH;
              end else begin
                line_cnt_q <= line_cnt_q + 16'd1;
              end
            end else begin
              col_cnt_q <= col_cnt_q + 16'd1;
            end
          end
        end
        FLUSH: begin
          flush_q <= flush_q - FW'(1);
          if (flush_q == FW'(1)) state_q <= DONE;
        end
        DONE: begin
          rcvd_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (stack_oflow || stack_uflow) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_median_filter_line_ctrl.sv
// Randomized self-checking bench for median_filter_line_ctrl against a
// frame-level reference model driven by pixel counts.
module tb_median_filter_line_ctrl;

  localparam int SIZE = 3;
  localparam int DW   = 9;
  localparam int BUFL = 64;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cw = '0;
  logic [15:0]   cl = '0;
  logic          sv = 1'b0;
  logic [DW-1:0] sd = '0;
  logic          of = 1'b0;
  logic          uf = 1'b0;
  logic          busy, done, err, s_ready, wr, rd, cv;
  logic [DW-1:0] din;
  logic [15:0]   rcvd;

  median_filter_line_ctrl #(
    .SIZE(SIZE), .DW_FIFO(DW), .BUF_LEN(BUFL)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start),
    .cfg_line_width(cw), .cfg_num_lines(cl),
    .busy(busy), .done(done), .err(err),
    .s_valid(sv), .s_data(sd), .s_ready(s_ready),
    .line_stack_wr_en(wr), .line_stack_din(din),
    .line_stack_glb_rd_en(rd), .rcvd_line_cntr(rcvd),
    .stack_oflow(of), .stack_uflow(uf), .col_valid(cv)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: phase 0 idle, 1 stream, 2 flush, 3 done
  int   ph = 0, k = 0, N = 0, W = 1, L = 0, F = 0, fc = 0, rfin = 0;
  logic e_cv = 1'b0, e_err = 1'b0;
  int   a_wr, a_rd, a_cv, a_fl, a_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic [15:0] w,
                      input logic [15:0] l, input logic v,
                      input logic u);
    logic acc;
    int   er;
    @(posedge clk);
    #1;
    start = st; cw = w; cl = l; sv = v;
    sd = DW'($urandom); uf = u; of = 1'b0;
    @(negedge clk);
    acc = (ph == 1) && v;
    if (ph == 0) er = 0;
    else if (ph == 1) er = (k / W < SIZE) ? k / W : SIZE;
    else er = rfin;
    chk("s_ready", 32'(s_ready), 32'(ph == 1));
    chk("wr_en", 32'(wr), 32'(acc));
    chk("din", 32'(din), acc ? 32'(sd) : 32'd0);
    chk("rd_en", 32'(rd), 32'((acc && k >= W) || ph == 2));
    chk("rcvd", 32'(rcvd), er);
    chk("col_valid", 32'(cv), 32'(e_cv));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("done", 32'(done), 32'(ph == 3));
    chk("err", 32'(err), 32'(e_err));
    a_wr += int'(wr);
    a_cv += int'(cv);
    a_done += int'(done);
    if (rd && ph == 1) a_rd++;
    if (rd && ph == 2) a_fl++;
    e_cv = acc && (k >= W * SIZE);
    case (ph)
      0: if (st) begin
        e_err = 1'b0;
        if (w == 0 || l == 0) begin
          ph = 3; rfin = 0;
        end else if (int'(w) > BUFL) begin
          ph = 3; rfin = 0; e_err = 1'b1;
        end else begin
          W = w; L = l; ph = 1; k = 0; N = W * L; fc = 0;
          rfin = (L < SIZE) ? L : SIZE;
          F = W * rfin;
        end
      end
      1: if (acc) begin
        k++;
        if (k == N) ph = 2;
      end
      2: begin
        fc++;
        if (fc == F) ph = 3;
      end
      default: ph = 0;
    endcase
    if (u) e_err = 1'b1;
  endtask

  task automatic run_frame(input int w, input int l, input int mode,
                           input int uf_at);
    int   guard;
    logic v, u, fired;
    a_wr = 0; a_rd = 0; a_cv = 0; a_fl = 0; a_done = 0;
    fired = 1'b0;
    guard = 0;
    step(1'b1, 16'(w), 16'(l), 1'b0, 1'b0);
    while (ph != 0 && guard < 4000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = guard[0];
      else v = 1'($urandom_range(0, 1));
      u = (ph == 1) && (k == uf_at) && !fired;
      if (u) fired = 1'b1;
      step(1'b0, 16'(w), 16'(l), v, u);
      guard++;
    end
    step(1'b0, 16'(w), 16'(l), 1'b0, 1'b0);
    chk("n_done", a_done, 1);
    if (w == 0 || l == 0 || w > BUFL) begin
      chk("n_wr", a_wr, 0);
      chk("n_rd", a_rd + a_fl, 0);
    end else begin
      chk("n_wr", a_wr, w * l);
      chk("n_rd", a_rd, (l - 1) * w);
      chk("n_cv", a_cv, (l > SIZE) ? (l - SIZE) * w : 0);
      chk("n_flush", a_fl, w * ((l < SIZE) ? l : SIZE));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 0);
    chk({tag, "_wr"}, 32'(wr), 0);
    chk({tag, "_din"}, 32'(din), 0);
    chk({tag, "_rd"}, 32'(rd), 0);
    chk({tag, "_rcvd"}, 32'(rcvd), 0);
    chk({tag, "_cv"}, 32'(cv), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    int guard;
    #1;
    chk_zero("rst");
    repeat (2) @(negedge clk);
    rstb = 1'b1;

    run_frame(4, 5, 0, -1);
    run_frame(4, 5, 1, -1);
    run_frame(4, 2, 0, -1);
    run_frame(4, 0, 0, -1);
    run_frame(4, 5, 2, 7);
    run_frame(3, 3, 2, -1);
    run_frame(100, 2, 0, -1);
    run_frame(1, 1, 0, -1);
    repeat (6)
      run_frame($urandom_range(1, 8), $urandom_range(1, 6), 2, -1);

    step(1'b1, 16'd4, 16'd5, 1'b0, 1'b0);
    guard = 0;
    while (!(ph == 2 && fc == 3) && guard < 200) begin
      step(1'b0, 16'd4, 16'd5, 1'b1, 1'b0);
      guard++;
    end
    chk("reach_flush", 32'(busy && !s_ready && rd), 1);
    #2 rstb = 1'b0;
    #1 chk_zero("arst");
    ph = 0; e_cv = 1'b0; e_err = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_done", 32'(done), 0);
    end
    rstb = 1'b1;
    run_frame(4, 5, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
